// File: rtl/axil_mem_pkg.sv
// axil_mem_pkg: response codes and channel state encodings shared by the AXI-Lite memory
package axil_mem_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID} r_state_e;
endpackage

// File: rtl/axil_mem_array.sv
// axil_mem_array: WORDS x DW storage, byte-enabled write port, registered read port (we_i/waddr_i/wdata_i/wstrb_i write, re_i/raddr_i in, rdata_o out)
module axil_mem_array #(
  parameter int DW    = 32,
  parameter int WORDS = 1024,
  parameter int IW    = 10
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [IW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic            re_i,
  input  logic [IW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++)
      if (we_i && wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/axil_dual_channel_memory.sv
// axil_dual_channel_memory: AXI-Lite slave memory with independent write (AW/W/B) and read (AR/R) channel FSMs; clk/rst_n plus s_axi_* channels
module axil_dual_channel_memory
  import axil_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);
  localparam int OFF = $clog2(DATA_WIDTH/8);
  localparam int IW  = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_WORDS);
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic up_q, rerr_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, w_idx, r_idx;
  logic [DATA_WIDTH-1:0] wdata_q, w_data, mem_rdata;
  logic [DATA_WIDTH/8-1:0] wstrb_q, w_strb;
  logic [1:0] bresp_q;
  logic aw_hs, w_hs, ar_hs, w_fire, w_ok, r_ok;
  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  // the half that arrived first comes from the holding register, the other straight off the bus
  assign w_idx  = ((w_state_q == W_HAVE_AW) ? awaddr_q : s_axi_awaddr) >> OFF;
  assign w_data = (w_state_q == W_HAVE_W) ? wdata_q : s_axi_wdata;
  assign w_strb = (w_state_q == W_HAVE_W) ? wstrb_q : s_axi_wstrb;
  assign w_ok   = w_idx < LIMIT;
  assign r_idx  = s_axi_araddr >> OFF;
  assign r_ok   = r_idx < LIMIT;
  assign w_fire = (w_state_q != W_RESP) && (w_state_d == W_RESP);
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:    w_state_d = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : W_IDLE;
      W_HAVE_AW: w_state_d = w_hs ? W_RESP : W_HAVE_AW;
      W_HAVE_W:  w_state_d = aw_hs ? W_RESP : W_HAVE_W;
      W_RESP:    w_state_d = s_axi_bready ? W_IDLE : W_RESP;
      default:   w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  r_state_d = ar_hs ? ((READ_LATENCY == 2) ? R_WAIT : R_VALID) : R_IDLE;
      R_WAIT:  r_state_d = R_VALID;
      R_VALID: r_state_d = s_axi_rready ? R_IDLE : R_VALID;
      default: r_state_d = R_IDLE;
    endcase
  end
  // up_q keeps every ready low until the first edge after reset release
  always_comb begin
    s_axi_awready = up_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_W);
    s_axi_wready  = up_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_AW);
    s_axi_bvalid  = w_state_q == W_RESP;
    s_axi_bresp   = bresp_q;
    s_axi_arready = up_q && r_state_q == R_IDLE;
    s_axi_rvalid  = r_state_q == R_VALID;
    s_axi_rresp   = rerr_q ? RESP_SLVERR : RESP_OKAY;
    s_axi_rdata   = (s_axi_rvalid && !rerr_q) ? mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q      <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rerr_q    <= 1'b0;
    end else begin
      up_q      <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (w_fire) bresp_q <= w_ok ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) rerr_q <= !r_ok;
    end
  end
  axil_mem_array #(.DW(DATA_WIDTH), .WORDS(MEM_WORDS), .IW(IW)) u_mem (
    .clk     (clk),
    .we_i    (w_fire && w_ok),
    .waddr_i (w_idx[IW-1:0]),
    .wdata_i (w_data),
    .wstrb_i (w_strb),
    .re_i    (ar_hs && r_ok),
    .raddr_i (r_idx[IW-1:0]),
    .rdata_o (mem_rdata)
  );
endmodule

// File: tb/tb_axil_dual_channel_memory.sv
// tb_axil_dual_channel_memory: drives two configurations (1000 words/latency 2 and defaults) from shared inputs
module tb_axil_dual_channel_memory;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [1:0] a_bresp, a_rresp, b_bresp, b_rresp;
  logic [31:0] a_rdata, b_rdata;
  int checks = 0, errors = 0;
  axil_dual_channel_memory #(.MEM_WORDS(1000), .READ_LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(a_awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(a_wready),
    .s_axi_bresp(a_bresp), .s_axi_bvalid(a_bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(a_arready),
    .s_axi_rdata(a_rdata), .s_axi_rresp(a_rresp), .s_axi_rvalid(a_rvalid), .s_axi_rready(rready)
  );
  axil_dual_channel_memory dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(b_awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(b_wready),
    .s_axi_bresp(b_bresp), .s_axi_bvalid(b_bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(b_arready),
    .s_axi_rdata(b_rdata), .s_axi_rresp(b_rresp), .s_axi_rvalid(b_rvalid), .s_axi_rready(rready)
  );
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] da;
    logic [1:0]  ra;
    logic [31:0] db;
    logic [1:0]  rb;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_write(input string n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] ea, input logic [1:0] eb);
    @(negedge clk);
    chk({n, " awready_a"}, a_awready, 1);
    chk({n, " wready_b"}, b_wready, 1);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk({n, " bvalid_a"}, a_bvalid, 1);
    chk({n, " bresp_a"}, a_bresp, ea);
    chk({n, " bvalid_b"}, b_bvalid, 1);
    chk({n, " bresp_b"}, b_bresp, eb);
    chk({n, " awready_busy"}, a_awready, 0);
    @(negedge clk);
    chk({n, " bvalid_a_done"}, a_bvalid, 0);
    chk({n, " awready_a_back"}, a_awready, 1);
  endtask
  task automatic do_read(input string n, input logic [31:0] a, input logic [31:0] da, input logic [1:0] ra,
                         input logic [31:0] db, input logic [1:0] rb);
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    @(negedge clk);
    arvalid = 0;
    chk({n, " rvalid_b"}, b_rvalid, 1);
    chk({n, " rdata_b"}, b_rdata, db);
    chk({n, " rresp_b"}, b_rresp, rb);
    chk({n, " rvalid_a_early"}, a_rvalid, 0);
    @(negedge clk);
    chk({n, " rvalid_a"}, a_rvalid, 1);
    chk({n, " rdata_a"}, a_rdata, da);
    chk({n, " rresp_a"}, a_rresp, ra);
    chk({n, " rvalid_b_done"}, b_rvalid, 0);
    @(negedge clk);
    chk({n, " rvalid_a_done"}, a_rvalid, 0);
    chk({n, " arready_a"}, a_arready, 1);
    chk({n, " arready_b"}, b_arready, 1);
  endtask
  initial begin
    awaddr = 0; wdata = 0; araddr = 0; wstrb = 0;
    awvalid = 0; wvalid = 0; bready = 1; arvalid = 0; rready = 1;
    vecs.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        OK, 32'h0,        OK});
    vecs.push_back('{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, OK, 32'hDEADBEEF, OK});
    vecs.push_back('{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        OK, 32'h0,        OK});
    vecs.push_back('{1'b1, 32'hF9C,      32'h99999999, 4'hF, 32'h0,        OK, 32'h0,        OK});
    vecs.push_back('{1'b1, 32'hFA0,      32'hCAFEF00D, 4'hF, 32'h0,        SE, 32'h0,        OK});
    vecs.push_back('{1'b0, 32'hFA0,      32'h0,        4'h0, 32'h0,        SE, 32'hCAFEF00D, OK});
    vecs.push_back('{1'b0, 32'hF9C,      32'h0,        4'h0, 32'h99999999, OK, 32'h99999999, OK});
    vecs.push_back('{1'b1, 32'h30,       32'h12345678, 4'hF, 32'h0,        OK, 32'h0,        OK});
    vecs.push_back('{1'b1, 32'h30,       32'hFFFFFFFF, 4'h0, 32'h0,        OK, 32'h0,        OK});
    vecs.push_back('{1'b0, 32'h30,       32'h0,        4'h0, 32'h12345678, OK, 32'h12345678, OK});
    vecs.push_back('{1'b1, 32'h40,       32'h00000000, 4'hF, 32'h0,        OK, 32'h0,        OK});
    vecs.push_back('{1'b1, 32'h40,       32'hAABBCCDD, 4'hA, 32'h0,        OK, 32'h0,        OK});
    vecs.push_back('{1'b0, 32'h43,       32'h0,        4'h0, 32'hAA00CC00, OK, 32'hAA00CC00, OK});
    vecs.push_back('{1'b1, 32'h10000010, 32'h00000001, 4'hF, 32'h0,        SE, 32'h0,        SE});
    vecs.push_back('{1'b0, 32'h10000010, 32'h0,        4'h0, 32'h0,        SE, 32'h0,        SE});
    vecs.push_back('{1'b1, 32'h60,       32'h600DCAFE, 4'hF, 32'h0,        OK, 32'h0,        OK});
    repeat (3) @(negedge clk);
    chk("rst awready", {a_awready, b_awready}, 0);
    chk("rst wready", {a_wready, b_wready}, 0);
    chk("rst arready", {a_arready, b_arready}, 0);
    chk("rst bvalid", {a_bvalid, b_bvalid}, 0);
    chk("rst rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst resp", {a_bresp, a_rresp, b_bresp, b_rresp}, 0);
    chk("rst rdata", {a_rdata, b_rdata}, 0);
    rst_n = 1;
    #1 chk("release awready", a_awready, 0);
    @(posedge clk); #1;
    chk("first edge ready_a", {a_awready, a_wready, a_arready}, 3'b111);
    chk("first edge ready_b", {b_awready, b_wready, b_arready}, 3'b111);
    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write($sformatf("v%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].ra, vecs[i].rb);
      else do_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].da, vecs[i].ra, vecs[i].db, vecs[i].rb);
    end
    // W three cycles ahead of AW, then bready held low for five cycles
    @(negedge clk);
    wdata = 32'hAAAA5555; wstrb = 4'h3; wvalid = 1; bready = 0;
    @(negedge clk);
    wvalid = 0;
    chk("wfirst wready", a_wready, 0);
    chk("wfirst awready", a_awready, 1);
    chk("wfirst bvalid", a_bvalid, 0);
    @(negedge clk);
    @(negedge clk);
    awaddr = 32'h20; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d bvalid", k), {a_bvalid, b_bvalid}, 2'b11);
      chk($sformatf("hold%0d bresp", k), {a_bresp, b_bresp}, 0);
      chk($sformatf("hold%0d readies", k), {a_awready, a_wready, b_awready, b_wready}, 0);
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    chk("hold release bvalid", a_bvalid, 0);
    chk("hold release ready", {a_awready, a_wready, b_awready}, 3'b111);
    do_read("wfirst rd", 32'h20, 32'h11225555, OK, 32'h11225555, OK);
    // AW one cycle ahead of W
    @(negedge clk);
    awaddr = 32'h50; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    chk("awfirst ready", {a_awready, a_wready, a_bvalid}, 3'b010);
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    chk("awfirst bvalid", {a_bvalid, b_bvalid}, 2'b11);
    chk("awfirst bresp", a_bresp, OK);
    @(negedge clk);
    do_read("awfirst rd", 32'h50, 32'h0BADF00D, OK, 32'h0BADF00D, OK);
    // write and read of the same word on the same edge
    @(negedge clk);
    awaddr = 32'h60; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h60; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("rbw bvalid", {a_bvalid, b_bvalid}, 2'b11);
    chk("rbw rvalid_b", b_rvalid, 1);
    chk("rbw rdata_b", b_rdata, 32'h600DCAFE);
    chk("rbw rvalid_a_early", a_rvalid, 0);
    @(negedge clk);
    chk("rbw rvalid_a", a_rvalid, 1);
    chk("rbw rdata_a", a_rdata, 32'h600DCAFE);
    @(negedge clk);
    chk("rbw rvalid_a_done", a_rvalid, 0);
    do_read("rbw new", 32'h60, 32'h5, OK, 32'h5, OK);
    // reset while a read response is pending
    @(negedge clk);
    araddr = 32'h10; arvalid = 1; rready = 0;
    @(negedge clk);
    arvalid = 0;
    chk("mid b_rvalid", b_rvalid, 1);
    chk("mid a_rvalid_early", a_rvalid, 0);
    @(negedge clk);
    chk("mid a_rvalid", a_rvalid, 1);
    chk("mid a_rdata", a_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("mid hold", {a_rvalid, b_rvalid, a_arready}, 3'b110);
    chk("mid hold rdata", b_rdata, 32'hDEADBEEF);
    #2 rst_n = 0;
    #1;
    chk("async rvalid", {a_rvalid, b_rvalid}, 0);
    chk("async ready", {a_arready, a_awready, b_arready}, 0);
    chk("async rdata", {a_rdata, b_rdata}, 0);
    @(negedge clk);
    rst_n = 1; rready = 1;
    #1 chk("post rst arready", a_arready, 0);
    @(posedge clk); #1;
    chk("post rst ready", {a_arready, b_arready, a_awready}, 3'b111);
    chk("post rst rvalid", {a_rvalid, b_rvalid}, 0);
    do_read("retain", 32'h10, 32'hDEADBEEF, OK, 32'hDEADBEEF, OK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
